// File: rtl/wch_sequencer.sv
// Learning-request sequencer feeding weight_change: queues per-neuron requests and runs one M-input sweep each.
// Optional learning-rate decay on epoch_tick is built when WCH_LR_DECAY_EN is defined.
module wch_sequencer #(
    parameter int          M        = 784,
    parameter int          N        = 8,
    parameter int          QD       = 4,
    parameter logic [23:0] DWP_INIT = 24'd40,
    parameter logic [23:0] DWM_INIT = 24'd40,
    parameter int          DECAY_SH = 4,
    parameter logic [23:0] DW_MIN   = 24'd4,
    parameter int          TMO      = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [$clog2(N)-1:0] req_neuron,
    input  logic                 req_pol,
    output logic                 req_ready,
    input  logic                 epoch_tick,
    input  logic                 valid_wch,
    output logic                 start_wch,
    output logic                 spike_hold,
    output logic [$clog2(M)-1:0] ip_select,
    output logic [$clog2(N)-1:0] neuron_sel,
    output logic [23:0]          del_w_plus,
    output logic [23:0]          del_w_minus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_tmo,
    output logic [1:0]           dbg_state
);

    // Handshake: a request transfers on every clk edge where req_valid && req_ready;
    // req_ready depends only on FIFO fill, never on req_valid.

    localparam int NW  = $clog2(N);
    localparam int IPW = $clog2(M);
    localparam int PW  = $clog2(QD);
    localparam int CW  = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NW:0]    fifo_q [QD];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    count_q;
    logic [NW:0]    head;
    logic           fifo_empty;
    logic           push, pop;
    logic           decay_go;

    logic [IPW-1:0] ip_q, ip_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NW-1:0]  nsel_q, nsel_d;
    logic           hold_q, hold_d;
    logic           start_q, start_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    assign fifo_empty = (count_q == '0);
    assign req_ready  = (count_q != (PW + 1)'(QD));
    assign push       = req_valid && req_ready;
    assign head       = fifo_q[rd_ptr_q];

    // Entries are {polarity, neuron id}; push and pop may share a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {req_pol, req_neuron};
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef WCH_LR_DECAY_EN
    logic [23:0] dwp_q, dwm_q;
    logic        pend_q;

    function automatic logic [23:0] decay_step(input logic [23:0] x);
        logic [23:0] y;
        y = x - (x >> DECAY_SH);
        return (y < DW_MIN) ? DW_MIN : y;
    endfunction

    // A pending tick wins over popping, so rates never move inside a sweep.
    assign decay_go = (state_q == S_IDLE) && (pend_q || (epoch_tick && fifo_empty));

    always_ff @(posedge clk) begin
        if (rst) begin
            dwp_q  <= DWP_INIT;
            dwm_q  <= DWM_INIT;
            pend_q <= 1'b0;
        end else if (decay_go) begin
            dwp_q  <= decay_step(dwp_q);
            dwm_q  <= decay_step(dwm_q);
            pend_q <= 1'b0;
        end else if (epoch_tick) begin
            pend_q <= 1'b1;
        end
    end

    assign del_w_plus  = dwp_q;
    assign del_w_minus = dwm_q;
`else
    logic [23:0] unused_cfg;

    assign unused_cfg  = DW_MIN ^ 24'(DECAY_SH) ^ {23'd0, epoch_tick};
    assign decay_go    = 1'b0;
    assign del_w_plus  = DWP_INIT;
    assign del_w_minus = DWM_INIT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ip_q    <= '0;
            cnt_q   <= '0;
            nsel_q  <= '0;
            hold_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            cnt_q   <= cnt_d;
            nsel_q  <= nsel_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!decay_go && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (ip_q == IPW'(M - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (valid_wch || (cnt_q == CW'(TMO - 1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ip_d    = ip_q;
        cnt_d   = cnt_q;
        nsel_d  = nsel_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    start_d = 1'b1;
                    ip_d    = '0;
                    nsel_d  = head[NW-1:0];
                    hold_d  = head[NW];
                end
            end
            S_SWEEP: begin
                if (ip_q == IPW'(M - 1)) begin
                    ip_d  = '0;
                    cnt_d = '0;
                end else begin
                    ip_d = ip_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (valid_wch) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(TMO - 1)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign start_wch  = start_q;
    assign ip_select  = ip_q;
    assign neuron_sel = nsel_q;
    assign spike_hold = hold_q;
    assign done       = done_q;
    assign err_tmo    = err_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wch_sequencer.sv
// Bench for wch_sequencer: directed scenarios plus random traffic against a timing-level reference model.
module tb_wch_sequencer;

    localparam int M   = 784;
    localparam int TMO = 15;
    localparam int QD  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_pol, epoch_tick, valid_wch;
    logic [2:0]  req_neuron;
    logic        req_ready, start_wch, spike_hold, busy, done, err_tmo;
    logic [9:0]  ip_select;
    logic [2:0]  neuron_sel;
    logic [23:0] del_w_plus, del_w_minus;
    logic [1:0]  dbg_state;

    wch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_neuron (req_neuron),
        .req_pol    (req_pol),
        .req_ready  (req_ready),
        .epoch_tick (epoch_tick),
        .valid_wch  (valid_wch),
        .start_wch  (start_wch),
        .spike_hold (spike_hold),
        .ip_select  (ip_select),
        .neuron_sel (neuron_sel),
        .del_w_plus (del_w_plus),
        .del_w_minus(del_w_minus),
        .busy       (busy),
        .done       (done),
        .err_tmo    (err_tmo),
        .dbg_state  (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model: pending requests {k, pol, neuron}, where k is the DRAIN
    // cycle at which valid_wch is returned (15 = never, expect timeout).
    logic [7:0] exp_q[$];
    int m_s, m_x, m_k, m_nrn, m_pol, m_dwp, m_dwm;
    bit m_pend;

    bit d_rv, d_pol, d_tick, d_stray, d_rst, noise;
    int d_nrn, d_k;

`ifdef WCH_LR_DECAY_EN
    localparam int EXP_D1 = 38;
    localparam int EXP_D2 = 36;
`else
    localparam int EXP_D1 = 40;
    localparam int EXP_D2 = 40;
`endif

    function automatic int decay(input int x);
        int y;
        y = x - x / 16;
        if (y < 4) y = 4;
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_s    = -1000000;
        m_x    = -1;
        m_k    = 0;
        m_nrn  = 0;
        m_pol  = 0;
        m_dwp  = 40;
        m_dwm  = 40;
        m_pend = 1'b0;
    endtask

    // One clock period: drive inputs, check every output, advance the model.
    task automatic cycle();
        int c;
        bit tick, stray, drain_win, exp_ready, idle, dec;
        logic [7:0] e;
        c         = cyc;
        tick      = d_tick;
        stray     = d_stray;
        drain_win = (c >= m_s + M) && (c < m_x);
        if (noise) begin
            if ($urandom_range(0, 99) == 0) tick = 1'b1;
            if (!drain_win && $urandom_range(0, 49) == 0) stray = 1'b1;
        end
        rst        = d_rst;
        req_valid  = d_rv;
        req_neuron = d_nrn[2:0];
        req_pol    = d_pol;
        epoch_tick = tick;
        valid_wch  = stray || (m_k < TMO && c == m_s + M + m_k);
        exp_ready  = (exp_q.size() < QD);
        if (chk_en) begin
            chk("start_wch", 32'(start_wch), 32'(c == m_s));
            chk("ip_select", 32'(ip_select), (c >= m_s && c < m_s + M) ? 32'(c - m_s) : 32'd0);
            chk("busy", 32'(busy), 32'(c >= m_s && c < m_x));
            chk("done", 32'(done), 32'(c == m_x && m_k < TMO));
            chk("err_tmo", 32'(err_tmo), 32'(c == m_x && m_k == TMO));
            chk("neuron_sel", 32'(neuron_sel), 32'(m_nrn));
            chk("spike_hold", 32'(spike_hold), 32'(m_pol));
            chk("del_w_plus", 32'(del_w_plus), 32'(m_dwp));
            chk("del_w_minus", 32'(del_w_minus), 32'(m_dwm));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
        end
        if (d_rst) begin
            model_reset();
            chk_en = 1'b1;
        end else begin
            idle = (c >= m_x);
            dec  = 1'b0;
`ifdef WCH_LR_DECAY_EN
            if (idle && (m_pend || (tick && exp_q.size() == 0))) dec = 1'b1;
            if (dec) begin
                m_dwp  = decay(m_dwp);
                m_dwm  = decay(m_dwm);
                m_pend = 1'b0;
            end else if (tick) begin
                m_pend = 1'b1;
            end
`endif
            if (idle && !dec && exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                m_nrn = int'(e[2:0]);
                m_pol = int'(e[3]);
                m_k   = int'(e[7:4]);
                m_s   = c + 1;
                m_x   = m_s + M + ((m_k == TMO) ? TMO : m_k + 1);
            end
            if (d_rv && exp_ready) begin
                exp_q.push_back({d_k[3:0], d_pol, d_nrn[2:0]});
            end
        end
        d_rv    = 1'b0;
        d_tick  = 1'b0;
        d_stray = 1'b0;
        d_rst   = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic req(input int nrn, input int pol, input int k);
        d_rv  = 1'b1;
        d_nrn = nrn;
        d_pol = pol[0];
        d_k   = k;
        cycle();
    endtask

    task automatic wait_until(input int t);
        for (int i = 0; i < 20000 && cyc < t; i++) cycle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30000 && !(cyc >= m_x && exp_q.size() == 0); i++) cycle();
    endtask

    initial begin
        int s, gap;
        model_reset();
        noise   = 1'b0;
        d_rv    = 1'b0;
        d_pol   = 1'b0;
        d_nrn   = 0;
        d_k     = 0;
        d_tick  = 1'b0;
        d_stray = 1'b0;

        d_rst = 1'b1;
        cycle();
        d_rst = 1'b1;
        cycle();
        run(2);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ip_select", 32'(ip_select), 32'd0);
        chk("rst_del_w_plus", 32'(del_w_plus), 32'd40);
        chk("rst_del_w_minus", 32'(del_w_minus), 32'd40);

        // Single request: start two cycles after the accept cycle.
        req(5, 1, 5);
        s = cyc + 1;
        run(1);
        chk("single_start", 32'(start_wch), 32'd1);
        chk("single_nsel", 32'(neuron_sel), 32'd5);
        chk("single_hold", 32'(spike_hold), 32'd1);
        chk("single_ip0", 32'(ip_select), 32'd0);
        wait_until(s + 783);
        chk("single_ip783", 32'(ip_select), 32'd783);
        run(7);
        chk("single_done", 32'(done), 32'd1);
        chk("single_busy_fall", 32'(busy), 32'd0);
        wait_idle();

        // Queue full behind an in-flight request.
        req(7, 1, int'($urandom_range(0, 14)));
        run(3);
        for (int i = 0; i < 5; i++) req(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 14)));
        chk("queue_full_ready", 32'(req_ready), 32'd0);
        wait_idle();

        // Timeout, then a normal request behind it.
        req(2, 0, TMO);
        s = cyc + 1;
        req(6, 1, 4);
        wait_until(s + M + TMO);
        chk("tmo_err", 32'(err_tmo), 32'd1);
        chk("tmo_no_done", 32'(done), 32'd0);
        wait_idle();

        // Stray valid_wch mid-sweep is ignored.
        req(3, 1, 3);
        s = cyc + 1;
        wait_until(s + 100);
        d_stray = 1'b1;
        cycle();
        chk("stray_busy", 32'(busy), 32'd1);
        chk("stray_ip", 32'(ip_select), 32'd101);
        wait_until(s + M - 1);
        chk("stray_ip783", 32'(ip_select), 32'd783);
        wait_idle();

        // Reset mid-sweep with requests queued.
        req(1, 1, 2);
        req(4, 0, 2);
        req(5, 1, 2);
        s = cyc - 1;
        wait_until(s + 400);
        d_rst = 1'b1;
        cycle();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ip", 32'(ip_select), 32'd0);
        chk("mrst_nsel", 32'(neuron_sel), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd1);
        run(900);

        // Epoch ticks: idle, mid-sweep, then repeated towards the floor.
        d_tick = 1'b1;
        cycle();
        run(1);
        chk("decay_idle", 32'(del_w_plus), 32'(EXP_D1));
        req(0, 1, 1);
        s = cyc + 1;
        wait_until(s + 50);
        d_tick = 1'b1;
        cycle();
        wait_until(s + M + 2);
        chk("decay_hold_drain", 32'(del_w_plus), 32'(EXP_D1));
        run(1);
        chk("decay_after_drain", 32'(del_w_plus), 32'(EXP_D2));
        for (int i = 0; i < 40; i++) begin
            d_tick = 1'b1;
            cycle();
            cycle();
        end

        // Random traffic with stray valid_wch and epoch ticks.
        noise = 1'b1;
        for (int i = 0; i < 10; i++) begin
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 900)) : int'($urandom_range(0, 3));
            run(gap);
            req(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end
        wait_idle();
        noise = 1'b0;
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
